cnn_data_path_gen2: RTL



---
 rtl/cnn_data_path_gen2_pkg.sv | 57 +++++
 rtl/cnn_data_path_gen2_if.sv | 27 ++
 rtl/cnn_data_path_gen2_mac.sv | 90 +++++++++
 rtl/cnn_data_path_gen2.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/cnn_data_path_gen2_pkg.sv
// Shared constants and types for the gen2 CNN datapath: bus codes, load/increment
// bit positions, ALU opcodes, MAC FSM states and the accumulator width helper.
package cnn_gen2_pkg;

  localparam logic [4:0] BUS_DR  = 5'd0;
  localparam logic [4:0] BUS_AC  = 5'd1;
  localparam logic [4:0] BUS_TR  = 5'd2;
  localparam logic [4:0] BUS_PC  = 5'd3;
  localparam logic [4:0] BUS_MEM = 5'd4;
  localparam logic [4:0] BUS_X   = 5'd5;
  localparam logic [4:0] BUS_Y   = 5'd6;
  localparam logic [4:0] BUS_IR  = 5'd7;
  localparam logic [4:0] BUS_G0  = 5'd8;

  localparam int unsigned LD_AC = 0;
  localparam int unsigned LD_DR = 1;
  localparam int unsigned LD_TR = 2;
  localparam int unsigned LD_IR = 3;
  localparam int unsigned LD_PC = 4;
  localparam int unsigned LD_AR = 5;
  localparam int unsigned LD_XY = 6;
  localparam int unsigned LD_G0 = 7;

  localparam int unsigned INC_PC = 0;
  localparam int unsigned INC_AR = 1;
  localparam int unsigned INC_X  = 2;
  localparam int unsigned INC_Y  = 3;

  localparam int unsigned FL_ZERO  = 0;
  localparam int unsigned FL_EQUAL = 1;
  localparam int unsigned FL_NEG   = 2;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_NOT    = 4'd5,
    ALU_SHL1   = 4'd6,
    ALU_SHR1   = 4'd7,
    ALU_PASS_B = 4'd8,
    ALU_INC    = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_RUN  = 2'd1,
    MAC_WB   = 2'd2
  } mac_state_e;

  // Wide enough that 2^len_w full-scale products can never overflow.
  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned len_w);
    return 2 * data_w + len_w;
  endfunction

endpackage

// File: rtl/cnn_data_path_gen2_if.sv
// MAC handshake and memory bus between the control unit (master) and datapath (slave).
interface cnn_data_path_gen2_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LEN_W  = 8
);
  logic              mac_start;
  logic              mac_clr;
  logic [LEN_W-1:0]  mac_len;
  logic              mac_in_valid;
  logic              mac_busy;
  logic              mac_done;
  logic              mac_sat;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] addr;

  modport master (
    output mac_start, mac_clr, mac_len, mac_in_valid, mem_rdata,
    input  mac_busy, mac_done, mac_sat, mem_wdata, addr
  );

  modport slave (
    input  mac_start, mac_clr, mac_len, mac_in_valid, mem_rdata,
    output mac_busy, mac_done, mac_sat, mem_wdata, addr
  );
endinterface

// File: rtl/cnn_data_path_gen2_mac.sv
// Multi-cycle signed MAC engine: counts mac_len products of bus*DR into a wide
// accumulator, then emits one write-back cycle with scaled, saturated result.
module cnn_mac_unit
  import cnn_gen2_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned FRAC   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              clr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              sat_o,
  output logic [DATA_W-1:0] wb_data_o
);
  localparam int unsigned ACC_W = acc_w(DATA_W, LEN_W);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  mac_state_e              state_q, state_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] shifted;
  logic                    clip_hi, clip_lo;

  always_comb begin
    prod    = (2*DATA_W)'($signed(a_i)) * (2*DATA_W)'($signed(b_i));
    shifted = acc_q >>> FRAC;
    clip_hi = shifted > MAXV;
    clip_lo = shifted < MINV;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    case (state_q)
      MAC_IDLE: begin
        if (start_i) begin
          cnt_d   = len_i;
          sat_d   = 1'b0;
          if (clr_i) acc_d = '0;
          state_d = (len_i == '0) ? MAC_WB : MAC_RUN;
        end
      end
      MAC_RUN: begin
        if (in_valid_i) begin
          acc_d = acc_q + ACC_W'(prod);
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = MAC_WB;
        end
      end
      MAC_WB: begin
        sat_d   = clip_hi | clip_lo;
        state_d = MAC_IDLE;
      end
      default: state_d = MAC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MAC_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  assign busy_o    = (state_q == MAC_RUN);
  assign done_o    = (state_q == MAC_WB);
  assign sat_o     = sat_q;
  assign wb_data_o = clip_hi ? {1'b0, {(DATA_W-1){1'b1}}} :
                     clip_lo ? {1'b1, {(DATA_W-1){1'b0}}} : shifted[DATA_W-1:0];
endmodule

// File: rtl/cnn_data_path_gen2.sv
// Gen2 CNN datapath: shared bus, core registers, general register file, flag unit,
// ALU feeding AC and a MAC engine whose write-back takes priority over ALU loads.
module cnn_data_path_gen2
  import cnn_gen2_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned NGPR   = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned FRAC   = 0
) (
  input  logic                clk,
  input  logic                rst,
  cnn_data_path_gen2_if.slave bus_if,
  input  logic [4:0]          bus_sel,
  input  logic [7+NGPR-1:0]   ld_vec,
  input  logic [1:0]          xy_sel,
  input  logic [3:0]          inc_vec,
  input  logic [3:0]          alu_op,
  input  logic [2:0]          flag_en,
  input  logic [DATA_W-1:0]   cmp_val,
  output logic [DATA_W-1:0]   ir_value,
  output logic [DATA_W-1:0]   ac_value,
  output logic [ADDR_W-1:0]   pc_value,
  output logic                zero,
  output logic                equal,
  output logic                neg
);
  localparam int unsigned GW = $clog2(NGPR);

  logic [DATA_W-1:0] ac_q, dr_q, tr_q, ir_q;
  logic [ADDR_W-1:0] pc_q, ar_q;
  logic [IDX_W-1:0]  x_q, y_q;
  logic [DATA_W-1:0] gpr_q [NGPR];
  logic              zero_q, equal_q, neg_q;

  logic [DATA_W-1:0] bus, alu_y, mac_wb_data;
  logic [4:0]        goff;
  logic              mac_wb;

  always_comb begin
    bus  = '0;
    goff = bus_sel - BUS_G0;
    case (bus_sel)
      BUS_DR:  bus = dr_q;
      BUS_AC:  bus = ac_q;
      BUS_TR:  bus = tr_q;
      BUS_PC:  bus = DATA_W'(pc_q);
      BUS_MEM: bus = bus_if.mem_rdata;
      BUS_X:   bus = DATA_W'(x_q);
      BUS_Y:   bus = DATA_W'(y_q);
      BUS_IR:  bus = ir_q;
      default: if (32'(goff) < NGPR) bus = gpr_q[goff[GW-1:0]];
    endcase
  end

  always_comb begin
    alu_y = ac_q;
    case (alu_op_e'(alu_op))
      ALU_ADD:    alu_y = ac_q + dr_q;
      ALU_SUB:    alu_y = ac_q - dr_q;
      ALU_AND:    alu_y = ac_q & dr_q;
      ALU_OR:     alu_y = ac_q | dr_q;
      ALU_XOR:    alu_y = ac_q ^ dr_q;
      ALU_NOT:    alu_y = ~ac_q;
      ALU_SHL1:   alu_y = {ac_q[DATA_W-2:0], 1'b0};
      ALU_SHR1:   alu_y = {ac_q[DATA_W-1], ac_q[DATA_W-1:1]};
      ALU_PASS_B: alu_y = dr_q;
      ALU_INC:    alu_y = ac_q + DATA_W'(1);
      default:    alu_y = ac_q;
    endcase
  end

  cnn_mac_unit #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .FRAC   (FRAC)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .start_i    (bus_if.mac_start),
    .clr_i      (bus_if.mac_clr),
    .len_i      (bus_if.mac_len),
    .in_valid_i (bus_if.mac_in_valid),
    .a_i        (bus),
    .b_i        (dr_q),
    .busy_o     (bus_if.mac_busy),
    .done_o     (mac_wb),
    .sat_o      (bus_if.mac_sat),
    .wb_data_o  (mac_wb_data)
  );

  // Loads take priority over increments; MAC write-back takes priority over ALU loads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ac_q    <= '0;
      dr_q    <= '0;
      tr_q    <= '0;
      ir_q    <= '0;
      pc_q    <= '0;
      ar_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      gpr_q   <= '{default: '0};
      zero_q  <= 1'b0;
      equal_q <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      if (mac_wb)                ac_q <= mac_wb_data;
      else if (ld_vec[LD_AC])    ac_q <= alu_y;
      if (ld_vec[LD_DR])         dr_q <= bus;
      if (ld_vec[LD_TR])         tr_q <= bus;
      if (ld_vec[LD_IR])         ir_q <= bus;
      if (ld_vec[LD_PC])         pc_q <= bus[ADDR_W-1:0];
      else if (inc_vec[INC_PC])  pc_q <= pc_q + ADDR_W'(1);
      if (ld_vec[LD_AR])         ar_q <= bus[ADDR_W-1:0];
      else if (inc_vec[INC_AR])  ar_q <= ar_q + ADDR_W'(1);
      if (ld_vec[LD_XY] && xy_sel[0]) x_q <= bus[IDX_W-1:0];
      else if (inc_vec[INC_X])        x_q <= x_q + IDX_W'(1);
      if (ld_vec[LD_XY] && xy_sel[1]) y_q <= bus[IDX_W-1:0];
      else if (inc_vec[INC_Y])        y_q <= y_q + IDX_W'(1);
      for (int unsigned k = 0; k < NGPR; k++) begin
        if (ld_vec[LD_G0+k]) gpr_q[k] <= bus;
      end
      if (flag_en[FL_ZERO])  zero_q  <= (bus == '0);
      if (flag_en[FL_EQUAL]) equal_q <= (bus == cmp_val);
      if (flag_en[FL_NEG])   neg_q   <= bus[DATA_W-1];
    end
  end

  assign bus_if.mac_done  = mac_wb;
  assign bus_if.mem_wdata = bus;
  assign bus_if.addr      = ar_q;
  assign ir_value = ir_q;
  assign ac_value = ac_q;
  assign pc_value = pc_q;
  assign zero     = zero_q;
  assign equal    = equal_q;
  assign neg      = neg_q;
endmodule
